// File: rtl/ad9958_spi_responder.sv
`timescale 1ns/1ps
// AD9958 serial-port responder: oversampled SCLK/CS_B/SDIO/IO_UPDATE feed shadow buffers that IO_UPDATE copies to the active words.
// Strobes are registered one clk after the decoding edge; there is no backpressure. Optional readback port: `AD9958_READBACK_EN.
module ad9958_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        sclk,
  input  logic        csb,
  input  logic        sdio,
  input  logic        io_update,
  output logic [31:0] ftw0,
  output logic [31:0] ftw1,
  output logic [13:0] pow0,
  output logic [13:0] pow1,
  output logic [9:0]  amp0,
  output logic [9:0]  amp1,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        update_pulse,
`ifdef AD9958_READBACK_EN
  output logic        sdo,
  output logic        sdo_oe,
`endif
  output logic        frame_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_INSTR, ST_DATA} state_t;

  function automatic logic [2:0] byte_count(input logic [4:0] a);
    case (a)
      5'h00:               byte_count = 3'd1;
      5'h01, 5'h03, 5'h06: byte_count = 3'd3;
      5'h02, 5'h05, 5'h07: byte_count = 3'd2;
      default:             byte_count = 3'd4;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, csb_sync_q, sdio_sync_q, iou_sync_q;
  logic sclk_s, csb_s, sdio_s, iou_s;
  logic sclk_prev_q, csb_prev_q, iou_prev_q;
  logic sclk_rise, csb_fall, iou_rise, bit_take;

  // csb synchronizer resets low so a frame already in flight at reset release is not seen as a new falling edge
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sclk_sync_q <= '0;
      csb_sync_q  <= '0;
      sdio_sync_q <= '0;
      iou_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      csb_prev_q  <= 1'b0;
      iou_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], csb};
      sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], sdio};
      iou_sync_q  <= {iou_sync_q[SYNC_STAGES-2:0], io_update};
      sclk_prev_q <= sclk_s;
      csb_prev_q  <= csb_s;
      iou_prev_q  <= iou_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync_q[SYNC_STAGES-1];
  assign iou_s     = iou_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign csb_fall  = ~csb_s & csb_prev_q;
  assign iou_rise  = iou_s & ~iou_prev_q;
  assign bit_take  = sclk_rise & ~csb_s;

  state_t      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [30:0] shift_q, shift_d;
  logic        rw_q, rw_d;
  logic [4:0]  addr_q, addr_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic        done, abort_err;
  logic [31:0] data_full;
  logic [5:0]  last_idx;

  assign data_full = {shift_q, sdio_s};
  assign last_idx  = {nbytes_q, 3'b000} - 6'd1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    nbytes_d  = nbytes_q;
    done      = 1'b0;
    abort_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (csb_fall) begin
          state_d   = ST_INSTR;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ST_INSTR: begin
        if (csb_s) begin
          state_d   = ST_IDLE;
          abort_err = (bit_cnt_q != 6'd0);
          bit_cnt_d = '0;
        end else if (bit_take) begin
          if (bit_cnt_q == 6'd7) begin
            rw_d      = shift_q[6];
            addr_d    = {shift_q[3:0], sdio_s};
            nbytes_d  = byte_count({shift_q[3:0], sdio_s});
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end else begin
            shift_d   = {shift_q[29:0], sdio_s};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      ST_DATA: begin
        if (csb_s) begin
          state_d   = ST_IDLE;
          abort_err = (bit_cnt_q != 6'd0);
          bit_cnt_d = '0;
        end else if (bit_take) begin
          if (bit_cnt_q == last_idx) begin
            done      = 1'b1;
            state_d   = ST_INSTR;
            bit_cnt_d = '0;
            shift_d   = '0;
          end else begin
            shift_d   = {shift_q[29:0], sdio_s};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      nbytes_q  <= 3'd1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      nbytes_q  <= nbytes_d;
    end
  end

  logic [7:0]  csr_q;
  logic [31:0] ftw_buf0_q, ftw_buf1_q, ftw_buf0_d, ftw_buf1_d;
  logic [13:0] pow_buf0_q, pow_buf1_q, pow_buf0_d, pow_buf1_d;
  logic [9:0]  amp_buf0_q, amp_buf1_q, amp_buf0_d, amp_buf1_d;
  logic [31:0] ftw0_q, ftw1_q;
  logic [13:0] pow0_q, pow1_q;
  logic [9:0]  amp0_q, amp1_q;
  logic        wr_valid_q, update_pulse_q, frame_err_q;
  logic [4:0]  wr_addr_q;
  logic [31:0] wr_data_q;
  logic        wr_ok, rd_ok, bad, wr_ch0, wr_ch1;

  assign wr_ok  = done & ~rw_q & (addr_q <= 5'h18);
  assign bad    = done & ~wr_ok & ~rd_ok;
  assign wr_ch0 = wr_ok & csr_q[6];
  assign wr_ch1 = wr_ok & csr_q[7];

  // next-buffer values also feed the active copy, so a commit coinciding with io_update is included
  assign ftw_buf0_d = (wr_ch0 && addr_q == 5'h04) ? data_full        : ftw_buf0_q;
  assign ftw_buf1_d = (wr_ch1 && addr_q == 5'h04) ? data_full        : ftw_buf1_q;
  assign pow_buf0_d = (wr_ch0 && addr_q == 5'h05) ? data_full[13:0] : pow_buf0_q;
  assign pow_buf1_d = (wr_ch1 && addr_q == 5'h05) ? data_full[13:0] : pow_buf1_q;
  assign amp_buf0_d = (wr_ch0 && addr_q == 5'h06) ? data_full[9:0]  : amp_buf0_q;
  assign amp_buf1_d = (wr_ch1 && addr_q == 5'h06) ? data_full[9:0]  : amp_buf1_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      csr_q          <= 8'hF0;
      ftw_buf0_q     <= '0;
      ftw_buf1_q     <= '0;
      pow_buf0_q     <= '0;
      pow_buf1_q     <= '0;
      amp_buf0_q     <= '0;
      amp_buf1_q     <= '0;
      ftw0_q         <= '0;
      ftw1_q         <= '0;
      pow0_q         <= '0;
      pow1_q         <= '0;
      amp0_q         <= '0;
      amp1_q         <= '0;
      wr_valid_q     <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      update_pulse_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      if (wr_ok && addr_q == 5'h00) begin
        csr_q <= data_full[7:0];
      end
      ftw_buf0_q     <= ftw_buf0_d;
      ftw_buf1_q     <= ftw_buf1_d;
      pow_buf0_q     <= pow_buf0_d;
      pow_buf1_q     <= pow_buf1_d;
      amp_buf0_q     <= amp_buf0_d;
      amp_buf1_q     <= amp_buf1_d;
      update_pulse_q <= iou_rise;
      if (iou_rise) begin
        ftw0_q <= ftw_buf0_d;
        ftw1_q <= ftw_buf1_d;
        pow0_q <= pow_buf0_d;
        pow1_q <= pow_buf1_d;
        amp0_q <= amp_buf0_d;
        amp1_q <= amp_buf1_d;
      end
      wr_valid_q <= wr_ok;
      if (wr_ok) begin
        wr_addr_q <= addr_q;
        wr_data_q <= data_full;
      end
      frame_err_q <= abort_err | bad;
    end
  end

`ifdef AD9958_READBACK_EN
  function automatic logic rb_addr_ok(input logic [4:0] a);
    rb_addr_ok = (a == 5'h00) || (a >= 5'h04 && a <= 5'h06);
  endfunction

  logic        sclk_fall, instr_done;
  logic [31:0] rb_val, rd_sh_q;
  logic        rd_act_q;

  assign sclk_fall  = ~sclk_s & sclk_prev_q;
  assign instr_done = (state_q == ST_INSTR) & bit_take & (bit_cnt_q == 6'd7);
  assign rd_ok      = done & rw_q & rb_addr_ok(addr_q);

  // readback words are left-aligned to the register's byte count so the MSB leaves first
  always_comb begin
    rb_val = '0;
    case (addr_d)
      5'h00:   rb_val = {csr_q, 24'h0};
      5'h04:   rb_val = ftw_buf0_q;
      5'h05:   rb_val = {2'b00, pow_buf0_q, 16'h0};
      5'h06:   rb_val = {14'h0, amp_buf0_q, 8'h0};
      default: rb_val = '0;
    endcase
  end

  // the fall right after the instruction byte must not shift: the first bit is already on sdo
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rd_sh_q  <= '0;
      rd_act_q <= 1'b0;
    end else if (instr_done) begin
      rd_sh_q  <= rb_val;
      rd_act_q <= rw_d & rb_addr_ok(addr_d);
    end else if (state_q == ST_DATA && sclk_fall && !csb_s && bit_cnt_q != 6'd0) begin
      rd_sh_q  <= {rd_sh_q[30:0], 1'b0};
    end
  end

  assign sdo    = rd_sh_q[31];
  assign sdo_oe = (state_q == ST_DATA) & rd_act_q;
`else
  logic unused_csr;
  assign rd_ok      = 1'b0;
  assign unused_csr = ^csr_q[5:0];
`endif

  assign ftw0         = ftw0_q;
  assign ftw1         = ftw1_q;
  assign pow0         = pow0_q;
  assign pow1         = pow1_q;
  assign amp0         = amp0_q;
  assign amp1         = amp1_q;
  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign update_pulse = update_pulse_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ad9958_spi_responder.sv
`timescale 1ns/1ps
// Bench for ad9958_spi_responder: directed SPI frames, expected strobes queued at issue time and matched by a monitor.
module tb_ad9958_spi_responder;

  logic        clk = 1'b0;
  logic        resetq, sclk, csb, sdio, io_update;
  logic [31:0] ftw0, ftw1, wr_data;
  logic [13:0] pow0, pow1;
  logic [9:0]  amp0, amp1;
  logic [4:0]  wr_addr;
  logic        wr_valid, update_pulse, frame_err;
`ifdef AD9958_READBACK_EN
  logic        sdo, sdo_oe;
`endif

  always #5 clk = ~clk;

  ad9958_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .resetq(resetq), .sclk(sclk), .csb(csb), .sdio(sdio), .io_update(io_update),
    .ftw0(ftw0), .ftw1(ftw1), .pow0(pow0), .pow1(pow1), .amp0(amp0), .amp1(amp1),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .update_pulse(update_pulse),
`ifdef AD9958_READBACK_EN
    .sdo(sdo), .sdo_oe(sdo_oe),
`endif
    .frame_err(frame_err)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t          wr_exp[$];
  string        err_exp[$];
  logic [111:0] upd_exp[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  wr_t          mon_wr;
  string        mon_s;
  logic [111:0] mon_u;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [111:0] snap(input logic [31:0] f0, input logic [31:0] f1,
                                        input logic [13:0] p0, input logic [13:0] p1,
                                        input logic [9:0] a0, input logic [9:0] a1);
    snap = {f0, f1, p0, p1, a0, a1};
  endfunction

  // monitor: every strobe must match the head of its queue
  always @(negedge clk) begin
    if (wr_valid) begin
      if (wr_exp.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_wr: got addr %0h data %0h, expected no write", wr_addr, wr_data);
      end else begin
        mon_wr = wr_exp.pop_front();
        check("wr", {wr_addr, wr_data}, mon_wr);
      end
    end
    if (frame_err) begin
      if (err_exp.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame_err: got frame_err 1, expected 0");
      end else begin
        mon_s = err_exp.pop_front();
      end
    end
    if (update_pulse) begin
      if (upd_exp.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_update: got update_pulse 1, expected 0");
      end else begin
        mon_u = upd_exp.pop_front();
        check("update_outputs", {ftw0, ftw1, pow0, pow1, amp0, amp1}, mon_u);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csb_low();
    csb = 1'b0;
    wait_clks(4);
  endtask

  task automatic csb_high();
    wait_clks(4);
    csb = 1'b1;
    wait_clks(8);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdio = v[i];
      wait_clks(4);
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d, input int nb);
    wr_exp.push_back({a, d});
    send_bits({27'h0, a}, 8);
    send_bits(d, 8 * nb);
  endtask

  task automatic pulse_update(input logic [111:0] exp, input string name);
    int lat;
    upd_exp.push_back(exp);
    lat = 0;
    io_update = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wait_clks(1);
      if (update_pulse) begin
        lat = k;
        break;
      end
    end
    check({name, "_latency"}, lat, 3);
    io_update = 1'b0;
    wait_clks(6);
    check({name, "_drained"}, upd_exp.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef AD9958_READBACK_EN
    logic [31:0] rb;
    logic        oe_all;
`endif
    resetq = 1'b0; sclk = 1'b0; csb = 1'b1; sdio = 1'b0; io_update = 1'b0;
    wait_clks(3);
    check("reset_outputs", {ftw0, ftw1, pow0, pow1, amp0, amp1}, 0);
    check("reset_strobes", {wr_valid, wr_addr, wr_data, update_pulse, frame_err}, 0);
    resetq = 1'b1;
    wait_clks(5);

    // ch0 only, then commit
    csb_low();
    write_reg(5'h00, 32'h40, 1);
    write_reg(5'h04, 32'h12345678, 4);
    csb_high();
    check("t1_writes_seen", wr_exp.size(), 0);
    pulse_update(snap(32'h12345678, 0, 0, 0, 0, 0), "t1");

    // both channels, multi-register frame
    csb_low();
    write_reg(5'h00, 32'hC0, 1);
    write_reg(5'h05, 32'h3FFF, 2);
    write_reg(5'h06, 32'h0003FF, 3);
    csb_high();
    check("t2_writes_seen", wr_exp.size(), 0);
    pulse_update(snap(32'h12345678, 0, 14'h3FFF, 14'h3FFF, 10'h3FF, 10'h3FF), "t2");

    // buffered until io_update
    csb_low();
    write_reg(5'h04, 32'hAAAA5555, 4);
    csb_high();
    check("t3_writes_seen", wr_exp.size(), 0);
    check("t3_ftw0_held", ftw0, 32'h12345678);
    pulse_update(snap(32'hAAAA5555, 32'hAAAA5555, 14'h3FFF, 14'h3FFF, 10'h3FF, 10'h3FF), "t3");

    // aborted after 20 data bits
    err_exp.push_back("t4_abort");
    csb_low();
    send_bits(32'h04, 8);
    send_bits(32'h13579BDF, 20);
    csb_high();
    check("t4_err_seen", err_exp.size(), 0);
    pulse_update(snap(32'hAAAA5555, 32'hAAAA5555, 14'h3FFF, 14'h3FFF, 10'h3FF, 10'h3FF), "t4");

    // out-of-range address
    err_exp.push_back("t5_bad_addr");
    csb_low();
    send_bits(32'h1A, 8);
    send_bits(32'hDEADBEEF, 32);
    csb_high();
    check("t5_err_seen", err_exp.size(), 0);

    // read of CFTW
`ifdef AD9958_READBACK_EN
    csb_low();
    send_bits(32'h84, 8);
    rb = '0;
    oe_all = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      sdio = 1'b0;
      wait_clks(4);
      rb[i] = sdo;
      oe_all = oe_all & sdo_oe;
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
    end
    csb_high();
    check("t5_readback_sdo", rb, 32'hAAAA5555);
    check("t5_readback_oe", oe_all, 1);
`else
    err_exp.push_back("t5_read");
    csb_low();
    send_bits(32'h84, 8);
    send_bits(32'h0, 32);
    csb_high();
    check("t5_read_err_seen", err_exp.size(), 0);
`endif

    // reset in the middle of a data phase, released with csb still low
    csb_low();
    send_bits(32'h04, 8);
    send_bits(32'h00000CAF, 12);
    resetq = 1'b0;
    wait_clks(2);
    check("t6_reset_outputs", {ftw0, ftw1, pow0, pow1, amp0, amp1}, 0);
    check("t6_reset_strobes", {wr_valid, wr_addr, wr_data, update_pulse, frame_err}, 0);
    resetq = 1'b1;
    wait_clks(4);
    send_bits(32'h000F00D5, 20);
    csb_high();
    csb_low();
    write_reg(5'h04, 32'h0BADF00D, 4);
    csb_high();
    check("t6_writes_seen", wr_exp.size(), 0);
    pulse_update(snap(32'h0BADF00D, 32'h0BADF00D, 0, 0, 0, 0), "t6");

    // CSR enables cleared: write strobes but buffers untouched
    csb_low();
    write_reg(5'h00, 32'h00, 1);
    write_reg(5'h04, 32'hFFFFFFFF, 4);
    csb_high();
    check("t7_writes_seen", wr_exp.size(), 0);
    pulse_update(snap(32'h0BADF00D, 32'h0BADF00D, 0, 0, 0, 0), "t7");

    wait_clks(10);
    check("final_queues_empty", wr_exp.size() + err_exp.size() + upd_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
